// File: rtl/grant_dispatcher.sv
// Decodes an accepted encoder index into a registered one-hot grant, held until release or timeout.
// Latency: grant appears 1 cycle after the transfer edge; idx_ready is high only in IDLE, followed by a 1-cycle dead gap.
module grant_dispatcher #(
  parameter int W = 4,
  parameter int MAX_HOLD = 16,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          idx_valid,
  output logic          idx_ready,
  input  logic [IW-1:0] idx_in,
  input  logic          idx_error,
  input  logic [W-1:0]  release_vec,
  output logic [W-1:0]  grant,
  output logic          busy,
  output logic          timeout,
  output logic          bad_idx,
  output logic [7:0]    grant_count,
  output logic [7:0]    timeout_count
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [IW:0]   W_LIM    = (IW+1)'(W);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [W-1:0]  r_grant;
  logic [HW-1:0] r_hold;
  logic          r_timeout;
  logic          r_bad_idx;
  logic [7:0]    r_grant_cnt;
  logic [7:0]    r_timeout_cnt;

  logic          w_xfer;
  logic          w_idx_ok;
  logic          w_release;
  logic          w_hold_max;
  logic [W-1:0]  w_grant_dec;

  assign w_xfer      = idx_valid & idx_ready;
  assign w_idx_ok    = ~idx_error & ({1'b0, idx_in} < W_LIM);
  assign w_grant_dec = W'(1) << idx_in;
  // r_grant is one-hot of the held index, so masking picks out only the owner's release bit
  assign w_release   = |(release_vec & r_grant);
  assign w_hold_max  = (r_hold == HOLD_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer && w_idx_ok) w_next_state = S_GRANT;
      S_GRANT: if (w_release || w_hold_max) w_next_state = S_GAP;
      S_GAP:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    idx_ready = 1'b0;
    busy      = 1'b0;
    if (reset_n && r_state == S_IDLE) idx_ready = 1'b1;
    if (r_state != S_IDLE)            busy      = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant       <= '0;
      r_hold        <= '0;
      r_timeout     <= 1'b0;
      r_bad_idx     <= 1'b0;
      r_grant_cnt   <= 8'd0;
      r_timeout_cnt <= 8'd0;
    end else begin
      r_timeout <= 1'b0;
      r_bad_idx <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_idx_ok) begin
              r_grant <= w_grant_dec;
              r_hold  <= '0;
              if (r_grant_cnt != 8'hFF) r_grant_cnt <= r_grant_cnt + 8'd1;
            end else begin
              r_bad_idx <= 1'b1;
            end
          end
        end
        S_GRANT: begin
          // release takes priority over an expiring hold
          if (w_release) begin
            r_grant <= '0;
          end else if (w_hold_max) begin
            r_grant   <= '0;
            r_timeout <= 1'b1;
            if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign grant         = r_grant;
  assign timeout       = r_timeout;
  assign bad_idx       = r_bad_idx;
  assign grant_count   = r_grant_cnt;
  assign timeout_count = r_timeout_cnt;

endmodule

// File: tb/tb_grant_dispatcher.sv
// Randomized and directed checks of grant_dispatcher against a cycle-level grant-ownership model.
module tb_grant_dispatcher;

  localparam int W        = 4;
  localparam int MAX_HOLD = 16;

  logic       clock;
  logic       reset_n;
  logic       idx_valid, idx_ready, idx_error;
  logic [1:0] idx_in;
  logic [3:0] release_vec, grant;
  logic       busy, timeout, bad_idx;
  logic [7:0] grant_count, timeout_count;

  logic       d3_valid, d3_ready, d3_err, d3_busy, d3_to, d3_bad;
  logic [1:0] d3_idx;
  logic [2:0] d3_rel, d3_grant;
  logic [7:0] d3_gcnt, d3_tcnt;

  grant_dispatcher #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .reset_n(reset_n), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_in(idx_in), .idx_error(idx_error), .release_vec(release_vec), .grant(grant),
    .busy(busy), .timeout(timeout), .bad_idx(bad_idx), .grant_count(grant_count),
    .timeout_count(timeout_count)
  );

  grant_dispatcher #(.W(3), .MAX_HOLD(MAX_HOLD)) dut3 (
    .clock(clock), .reset_n(reset_n), .idx_valid(d3_valid), .idx_ready(d3_ready),
    .idx_in(d3_idx), .idx_error(d3_err), .release_vec(d3_rel), .grant(d3_grant),
    .busy(d3_busy), .timeout(d3_to), .bad_idx(d3_bad), .grant_count(d3_gcnt),
    .timeout_count(d3_tcnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: who owns the grant, for how many visible cycles, and whether a dead cycle is pending
  int         m_owner, m_age, m_gcnt, m_tcnt;
  bit         m_gap, m_to, m_bad;
  logic [3:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_age = 0; m_gap = 0;
    m_gcnt = 0; m_tcnt = 0; m_to = 0; m_bad = 0;
    prev_grant = '0;
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic e, input logic [3:0] rv);
    idx_valid = v; idx_in = idx; idx_error = e; release_vec = rv;
  endtask

  task automatic step();
    logic       lv, le;
    logic [1:0] lidx;
    logic [3:0] lrv;
    int         eg;
    #1;
    check("idx_ready", 32'(idx_ready), (m_owner < 0 && !m_gap) ? 1 : 0);
    lv = idx_valid; le = idx_error; lidx = idx_in; lrv = release_vec;
    @(posedge clock);
    m_to = 0; m_bad = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner >= 0) begin
      if (lrv[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_age >= MAX_HOLD) begin
        m_owner = -1; m_gap = 1; m_to = 1;
        if (m_tcnt < 255) m_tcnt++;
      end else begin
        m_age++;
      end
    end else if (lv) begin
      if (le || int'(lidx) >= W) m_bad = 1;
      else begin
        m_owner = int'(lidx); m_age = 1;
        if (m_gcnt < 255) m_gcnt++;
      end
    end
    #1;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("grant", 32'(grant), eg);
    check("busy", 32'(busy), (m_owner >= 0 || m_gap) ? 1 : 0);
    check("timeout", 32'(timeout), m_to ? 1 : 0);
    check("bad_idx", 32'(bad_idx), m_bad ? 1 : 0);
    check("grant_count", 32'(grant_count), m_gcnt);
    check("timeout_count", 32'(timeout_count), m_tcnt);
    check("onehot0", 32'($onehot0(grant)), 1);
    if (prev_grant != 0 && grant != 0) check("no_overlap", 32'(grant), 32'(prev_grant));
    prev_grant = grant;
  endtask

  // Called just after a post-edge sample; reset is asserted and checked between clock edges
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_bad", 32'(bad_idx), 0);
    check("rst_gcnt", 32'(grant_count), 0);
    check("rst_tcnt", 32'(timeout_count), 0);
    check("rst_ready", 32'(idx_ready), 0);
    check("rst_d3_grant", 32'(d3_grant), 0);
    m_reset();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int hi, pulses;
    logic [3:0] rv;
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 4'd0);
    d3_valid = 1'b0; d3_idx = 2'd0; d3_err = 1'b0; d3_rel = 3'd0;
    m_reset();
    #12;
    check("init_grant", 32'(grant), 0);
    check("init_busy", 32'(busy), 0);
    check("init_gcnt", 32'(grant_count), 0);
    check("init_tcnt", 32'(timeout_count), 0);
    check("init_ready", 32'(idx_ready), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // grant idx 2, ignore foreign release bits, then release by owner
    drive(1'b1, 2'd2, 1'b0, 4'd0); step();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_gcnt", 32'(grant_count), 1);
    drive(1'b0, 2'd0, 1'b0, 4'd0); step();
    check("t1_ready", 32'(idx_ready), 0);
    drive(1'b0, 2'd0, 1'b0, 4'b1011);
    for (int i = 0; i < 3; i++) step();
    check("t2_held", 32'(grant), 32'h4);
    drive(1'b0, 2'd0, 1'b0, 4'b0100); step();
    check("t2_gap_grant", 32'(grant), 0);
    check("t2_gap_busy", 32'(busy), 1);
    drive(1'b0, 2'd0, 1'b0, 4'd0); step();
    check("t2_ready_after", 32'(idx_ready), 1);

    // timeout after exactly MAX_HOLD cycles
    drive(1'b1, 2'd0, 1'b0, 4'd0); step();
    drive(1'b0, 2'd0, 1'b0, 4'd0);
    hi = (grant != 0) ? 1 : 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant != 0) hi++;
      if (timeout) pulses++;
    end
    check("t3_span", hi, MAX_HOLD);
    check("t3_pulses", pulses, 1);
    check("t3_tcnt", 32'(timeout_count), 1);

    // bad indices: encoder error, and out-of-range on the 3-wide instance
    drive(1'b1, 2'd0, 1'b1, 4'd0);
    d3_valid = 1'b1; d3_idx = 2'd3;
    #1 check("t4_d3_ready", 32'(d3_ready), 1);
    step();
    check("t4_bad", 32'(bad_idx), 1);
    check("t4_gcnt", 32'(grant_count), 2);
    check("t4_d3_bad", 32'(d3_bad), 1);
    check("t4_d3_grant", 32'(d3_grant), 0);
    check("t4_d3_gcnt", 32'(d3_gcnt), 0);
    drive(1'b0, 2'd0, 1'b0, 4'd0);
    d3_valid = 1'b0;
    step();
    check("t4_d3_bad_clr", 32'(d3_bad), 0);
    d3_valid = 1'b1; d3_idx = 2'd2;
    step();
    check("t4_d3_grant2", 32'(d3_grant), 32'h4);
    check("t4_d3_gcnt2", 32'(d3_gcnt), 1);
    d3_valid = 1'b0; d3_rel = 3'b011;
    step();
    check("t4_d3_held", 32'(d3_grant), 32'h4);
    d3_rel = 3'b100;
    step();
    check("t4_d3_rel", 32'(d3_grant), 0);
    d3_rel = 3'b000;

    // release on the last allowed hold cycle beats the timeout
    drive(1'b1, 2'd1, 1'b0, 4'd0); step();
    drive(1'b0, 2'd0, 1'b0, 4'd0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step();
    check("t5_still_held", 32'(grant), 32'h2);
    drive(1'b0, 2'd0, 1'b0, 4'b0010); step();
    check("t5_no_pulse", 32'(timeout), 0);
    check("t5_tcnt", 32'(timeout_count), 1);
    drive(1'b0, 2'd0, 1'b0, 4'd0); step();

    // random traffic with occasional async resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rv = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) rv[m_owner] = 1'b0;
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), rv);
      step();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    // back-to-back grants to 1 and 3 drive the grant counter into saturation
    drive(1'b0, 2'd0, 1'b0, 4'd0);
    step();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, (i % 2 != 0) ? 2'd3 : 2'd1, 1'b0, 4'hF);
      step(); step(); step();
    end
    check("t6_gcnt_sat", 32'(grant_count), 255);
    drive(1'b1, 2'd3, 1'b0, 4'd0); step();
    drive(1'b0, 2'd0, 1'b0, 4'd0); step();
    check("t6_pre_reset_grant", 32'(grant), 32'h8);
    do_reset();
    step();
    check("t6_post_no_timeout", 32'(timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
